// File: rtl/wb_store_ctrl.sv
// -----------------------------------------------------------------------------
// wb_store_ctrl
// Writeback-stage control block. Consumes the WB pipeline latch outputs and
// performs the stage's store to the data cache. A store whose bytes cross a
// cache line is sent as two beats. The latch is stalled until the store has
// been fully accepted, after which the instruction retires for exactly one
// cycle and its register/segment/flag write enables are let through.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   i_v, i_mem_wr     latch holds a valid instruction / instruction is a store
//   i_cachable        store target is cachable
//   i_data1           store data, byte 0 at the lowest address
//   i_PA1, i_PA2      first-byte address / next-line address (split only)
//   i_size1, i_spill  store size code / bytes falling into the next line
//   i_reg_we1/2, i_seg_we, i_flag_we   decoded write requests
//   i_mem_ack         cache accepted the current request this cycle
//   o_mem_*           store request to the cache (fields valid with o_mem_req)
//   o_stall           hold the WB latch
//   o_retire          instruction completes this cycle
//   o_*_we            write enables qualified by o_retire
//   o_store_cnt       wrapping count of retired stores
// -----------------------------------------------------------------------------
module wb_store_ctrl #(
  parameter int PA_W   = 15,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_v,
  input  logic              i_mem_wr,
  input  logic              i_cachable,
  input  logic [DATA_W-1:0] i_data1,
  input  logic [PA_W-1:0]   i_PA1,
  input  logic [PA_W-1:0]   i_PA2,
  input  logic [1:0]        i_size1,
  input  logic [1:0]        i_spill,
  input  logic              i_reg_we1,
  input  logic              i_reg_we2,
  input  logic              i_seg_we,
  input  logic              i_flag_we,
  input  logic              i_mem_ack,
  output logic              o_mem_req,
  output logic [PA_W-1:0]   o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic [2:0]        o_mem_nbytes,
  output logic              o_mem_uc,
  output logic              o_stall,
  output logic              o_retire,
  output logic              o_reg_we1,
  output logic              o_reg_we2,
  output logic              o_seg_we,
  output logic              o_flag_we,
  output logic [CNT_W-1:0]  o_store_cnt
);

  typedef enum logic {
    S_IDLE,
    S_BEAT2
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [2:0]        w_n;
  logic [2:0]        w_s;
  logic [2:0]        w_n1;
  logic [5:0]        w_shift;
  logic              w_retire;

  // Store size in bytes and the part of it that spills into the next line.
  // A spill that is not smaller than the store size cannot describe a real
  // split, so it is treated as no split at all.
  always_comb begin
    unique case (i_size1)
      2'd0:    w_n = 3'd1;
      2'd1:    w_n = 3'd2;
      default: w_n = 3'd4;
    endcase
    w_s     = ({1'b0, i_spill} < w_n) ? {1'b0, i_spill} : 3'd0;
    w_n1    = w_n - w_s;
    // Beat 2 carries the bytes above those already sent in beat 1.
    w_shift = {w_n1, 3'b000};
  end

  // Next-state and request generation. Beat 1 is only ever driven from IDLE,
  // so once it is acked and we move to BEAT2 it cannot be reissued. Reset
  // forces everything quiet in the same cycle, even with a beat pending.
  always_comb begin
    w_next       = r_state;
    o_mem_req    = 1'b0;
    o_mem_addr   = '0;
    o_mem_wdata  = '0;
    o_mem_nbytes = '0;
    w_retire     = 1'b0;
    if (rst) begin
      w_next = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (i_v) begin
            if (i_mem_wr) begin
              o_mem_req    = 1'b1;
              o_mem_addr   = i_PA1;
              o_mem_nbytes = w_n1;
              o_mem_wdata  = i_data1;
              if (i_mem_ack) begin
                if (w_s == 3'd0) begin
                  w_retire = 1'b1;
                end else begin
                  w_next = S_BEAT2;
                end
              end
            end else begin
              w_retire = 1'b1;
            end
          end
        end
        S_BEAT2: begin
          o_mem_req    = 1'b1;
          o_mem_addr   = i_PA2;
          o_mem_nbytes = w_s;
          o_mem_wdata  = i_data1 >> w_shift;
          if (i_mem_ack) begin
            w_retire = 1'b1;
            w_next   = S_IDLE;
          end
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  // Stall is combinational on the ack so the latch advances in the very
  // cycle the final beat is accepted.
  always_comb begin
    o_retire    = w_retire;
    o_stall     = ~rst & i_v & i_mem_wr & ~w_retire;
    o_mem_uc    = ~i_cachable;
    o_reg_we1   = i_reg_we1 & w_retire;
    o_reg_we2   = i_reg_we2 & w_retire;
    o_seg_we    = i_seg_we & w_retire;
    o_flag_we   = i_flag_we & w_retire;
    o_store_cnt = r_cnt;
  end

  // State register and the wrapping retired-store counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_retire && i_mem_wr) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wb_store_ctrl.sv
// -----------------------------------------------------------------------------
// tb_wb_store_ctrl
// Self-checking bench for wb_store_ctrl. A byte-level model of the store
// rules predicts every output each cycle; directed vectors with literal
// expectations pin the model on the main scenarios and the boundaries.
// -----------------------------------------------------------------------------
module tb_wb_store_ctrl;

  localparam int PA_W  = 15;
  localparam int CNT_W = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            i_v = 1'b0;
  logic            i_mem_wr = 1'b0;
  logic            i_cachable = 1'b1;
  logic [31:0]     i_data1 = '0;
  logic [PA_W-1:0] i_PA1 = '0;
  logic [PA_W-1:0] i_PA2 = '0;
  logic [1:0]      i_size1 = '0;
  logic [1:0]      i_spill = '0;
  logic            i_reg_we1 = 1'b0;
  logic            i_reg_we2 = 1'b0;
  logic            i_seg_we = 1'b0;
  logic            i_flag_we = 1'b0;
  logic            i_mem_ack = 1'b0;

  logic             o_mem_req;
  logic [PA_W-1:0]  o_mem_addr;
  logic [31:0]      o_mem_wdata;
  logic [2:0]       o_mem_nbytes;
  logic             o_mem_uc;
  logic             o_stall;
  logic             o_retire;
  logic             o_reg_we1;
  logic             o_reg_we2;
  logic             o_seg_we;
  logic             o_flag_we;
  logic [CNT_W-1:0] o_store_cnt;

  int checks = 0;
  int errors = 0;

  wb_store_ctrl #(.PA_W(PA_W), .DATA_W(32), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .i_v(i_v), .i_mem_wr(i_mem_wr),
    .i_cachable(i_cachable), .i_data1(i_data1), .i_PA1(i_PA1), .i_PA2(i_PA2),
    .i_size1(i_size1), .i_spill(i_spill), .i_reg_we1(i_reg_we1),
    .i_reg_we2(i_reg_we2), .i_seg_we(i_seg_we), .i_flag_we(i_flag_we),
    .i_mem_ack(i_mem_ack), .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_nbytes(o_mem_nbytes), .o_mem_uc(o_mem_uc),
    .o_stall(o_stall), .o_retire(o_retire), .o_reg_we1(o_reg_we1),
    .o_reg_we2(o_reg_we2), .o_seg_we(o_seg_we), .o_flag_we(o_flag_we),
    .o_store_cnt(o_store_cnt)
  );

  // 10-unit clock period.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drive one cycle of latch outputs just after the rising edge.
  task automatic applyStimulus(input logic r, input logic v, input logic wr,
                               input logic [1:0] sz, input logic [1:0] sp,
                               input logic [PA_W-1:0] pa1,
                               input logic [PA_W-1:0] pa2,
                               input logic [31:0] d, input logic ack,
                               input logic [3:0] we, input logic c);
    @(posedge clk);
    #1;
    rst        = r;
    i_v        = v;
    i_mem_wr   = wr;
    i_size1    = sz;
    i_spill    = sp;
    i_PA1      = pa1;
    i_PA2      = pa2;
    i_data1    = d;
    i_mem_ack  = ack;
    i_reg_we1  = we[0];
    i_reg_we2  = we[1];
    i_seg_we   = we[2];
    i_flag_we  = we[3];
    i_cachable = c;
  endtask

  // ---------------- behavioural model ----------------
  function automatic int sizeBytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic int effSpill(input int n, input logic [1:0] sp);
    return (int'(sp) < n) ? int'(sp) : 0;
  endfunction

  // Bytes k..3 of d moved down to lane 0, upper lanes zero.
  function automatic logic [31:0] upperBytes(input logic [31:0] d, input int k);
    logic [31:0] r;
    r = '0;
    for (int j = 0; j < 4 - k; j++) r[8*j +: 8] = d[8*(j+k) +: 8];
    return r;
  endfunction

  int          mBeatsDone = 0;
  logic [15:0] mCnt = '0;
  logic        eReq = 1'b0;
  logic        eRet = 1'b0;
  logic [31:0] eAddr;
  logic [31:0] eNb;
  logic [31:0] eWd;
  logic        eStall;

  // Predict and compare all outputs every cycle, away from the active edge.
  always @(negedge clk) begin
    int n;
    int s;
    n = sizeBytes(i_size1);
    s = effSpill(n, i_spill);
    eReq = 1'b0; eRet = 1'b0; eAddr = '0; eNb = '0; eWd = '0;
    if (!rst) begin
      if (mBeatsDone > 0) begin
        eReq = 1'b1; eAddr = 32'(i_PA2); eNb = 32'(s);
        eWd = upperBytes(i_data1, n - s); eRet = i_mem_ack;
      end else if (i_v && i_mem_wr) begin
        eReq = 1'b1; eAddr = 32'(i_PA1); eNb = 32'(n - s);
        eWd = i_data1; eRet = i_mem_ack && (s == 0);
      end else begin
        eRet = i_v;
      end
    end
    eStall = !rst && i_v && i_mem_wr && !eRet;
    checkOutput("m_req", 32'(o_mem_req), 32'(eReq));
    checkOutput("m_retire", 32'(o_retire), 32'(eRet));
    checkOutput("m_stall", 32'(o_stall), 32'(eStall));
    checkOutput("m_uc", 32'(o_mem_uc), 32'(!i_cachable));
    checkOutput("m_we", {28'd0, o_flag_we, o_seg_we, o_reg_we2, o_reg_we1},
                {28'd0, i_flag_we & eRet, i_seg_we & eRet,
                 i_reg_we2 & eRet, i_reg_we1 & eRet});
    checkOutput("m_cnt", 32'(o_store_cnt), 32'(mCnt));
    if (eReq) begin
      checkOutput("m_addr", 32'(o_mem_addr), eAddr);
      checkOutput("m_nbytes", 32'(o_mem_nbytes), eNb);
      checkOutput("m_wdata", o_mem_wdata, eWd);
    end
  end

  // Advance the model's notion of beat progress and the store count.
  always @(posedge clk) begin
    if (rst) begin
      mBeatsDone <= 0;
      mCnt       <= '0;
    end else if (eRet) begin
      mBeatsDone <= 0;
      if (i_mem_wr) mCnt <= mCnt + 16'd1;
    end else if (eReq && i_mem_ack) begin
      mBeatsDone <= mBeatsDone + 1;
    end
  end

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [1:0]      sz;
    logic [1:0]      sp;
    logic [PA_W-1:0] pa1;
    logic [PA_W-1:0] pa2;
    logic [31:0]     d;
    logic [3:0]      we;
    logic            c;
    int              beats;
    logic [31:0]     lastNb;
    logic [31:0]     lastWd;
  } vec_t;

  vec_t vecs [4];

  initial begin
    vecs[0] = '{2'd1, 2'd1, 15'h01FF, 15'h0200, 32'h0000BEEF, 4'b1010, 1'b1, 2, 32'd1, 32'h000000BE};
    vecs[1] = '{2'd3, 2'd3, 15'h02FF, 15'h0300, 32'h89ABCDEF, 4'b0101, 1'b0, 2, 32'd3, 32'h0089ABCD};
    vecs[2] = '{2'd1, 2'd2, 15'h0400, 15'h0400, 32'h00005A5A, 4'b1111, 1'b1, 1, 32'd2, 32'h00005A5A};
    vecs[3] = '{2'd2, 2'd1, 15'h03FD, 15'h0400, 32'hDEADBEEF, 4'b0011, 1'b0, 2, 32'd1, 32'h000000DE};

    // Reset with a store presented: everything must stay quiet.
    applyStimulus(1, 1, 1, 2, 0, 15'h0100, 0, 32'hAABBCCDD, 1, 4'b1111, 1);
    @(negedge clk);
    checkOutput("rst_req", 32'(o_mem_req), 0);
    checkOutput("rst_stall", 32'(o_stall), 0);
    checkOutput("rst_retire", 32'(o_retire), 0);
    checkOutput("rst_we1", 32'(o_reg_we1), 0);
    checkOutput("rst_cnt", 32'(o_store_cnt), 0);

    // Non-store retires in the same cycle.
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 4'b0001, 1);
    @(negedge clk);
    checkOutput("ns_retire", 32'(o_retire), 1);
    checkOutput("ns_we1", 32'(o_reg_we1), 1);
    checkOutput("ns_stall", 32'(o_stall), 0);
    checkOutput("ns_req", 32'(o_mem_req), 0);

    // 4B store, ack held off for three cycles.
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 1, 1, 2, 0, 15'h0100, 0, 32'hAABBCCDD, 0, 4'b0001, 1);
      @(negedge clk);
      checkOutput("w4_stall", 32'(o_stall), 1);
      checkOutput("w4_req", 32'(o_mem_req), 1);
      checkOutput("w4_addr", 32'(o_mem_addr), 32'h0100);
      checkOutput("w4_wdata", o_mem_wdata, 32'hAABBCCDD);
      checkOutput("w4_cnt", 32'(o_store_cnt), 0);
    end
    applyStimulus(0, 1, 1, 2, 0, 15'h0100, 0, 32'hAABBCCDD, 1, 4'b0001, 1);
    @(negedge clk);
    checkOutput("w4_ack_retire", 32'(o_retire), 1);
    checkOutput("w4_ack_nbytes", 32'(o_mem_nbytes), 4);
    checkOutput("w4_ack_stall", 32'(o_stall), 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 1);
    @(negedge clk);
    checkOutput("w4_cnt_after", 32'(o_store_cnt), 1);

    // Split 4B store, immediate acks.
    applyStimulus(0, 1, 1, 2, 2, 15'h010E, 15'h0110, 32'h11223344, 1, 4'b0000, 1);
    @(negedge clk);
    checkOutput("sp_b1_addr", 32'(o_mem_addr), 32'h010E);
    checkOutput("sp_b1_nbytes", 32'(o_mem_nbytes), 2);
    checkOutput("sp_b1_wdata", o_mem_wdata, 32'h11223344);
    checkOutput("sp_b1_retire", 32'(o_retire), 0);
    checkOutput("sp_b1_stall", 32'(o_stall), 1);
    applyStimulus(0, 1, 1, 2, 2, 15'h010E, 15'h0110, 32'h11223344, 1, 4'b0000, 1);
    @(negedge clk);
    checkOutput("sp_b2_addr", 32'(o_mem_addr), 32'h0110);
    checkOutput("sp_b2_nbytes", 32'(o_mem_nbytes), 2);
    checkOutput("sp_b2_wdata", o_mem_wdata, 32'h00001122);
    checkOutput("sp_b2_retire", 32'(o_retire), 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 1);
    @(negedge clk);
    checkOutput("sp_cnt", 32'(o_store_cnt), 2);
    checkOutput("sp_idle_req", 32'(o_mem_req), 0);

    // 1B store with an impossible spill stays a single beat.
    applyStimulus(0, 1, 1, 0, 3, 15'h0123, 15'h0130, 32'h000000A5, 1, 4'b0000, 1);
    @(negedge clk);
    checkOutput("b1_nbytes", 32'(o_mem_nbytes), 1);
    checkOutput("b1_retire", 32'(o_retire), 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 1);
    @(negedge clk);
    checkOutput("b1_req_after", 32'(o_mem_req), 0);
    checkOutput("b1_cnt", 32'(o_store_cnt), 3);

    // Mixed sizes/spills, one stalled cycle before the acks.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1, 1, vecs[i].sz, vecs[i].sp, vecs[i].pa1, vecs[i].pa2,
                    vecs[i].d, 0, vecs[i].we, vecs[i].c);
      for (int b = 0; b < vecs[i].beats; b++) begin
        applyStimulus(0, 1, 1, vecs[i].sz, vecs[i].sp, vecs[i].pa1, vecs[i].pa2,
                      vecs[i].d, 1, vecs[i].we, vecs[i].c);
      end
      @(negedge clk);
      checkOutput("tbl_retire", 32'(o_retire), 1);
      checkOutput("tbl_nbytes", 32'(o_mem_nbytes), vecs[i].lastNb);
      checkOutput("tbl_wdata", o_mem_wdata, vecs[i].lastWd);
      checkOutput("tbl_flag_we", 32'(o_flag_we), 32'(vecs[i].we[3]));
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 1);
    end

    // Reset while beat 2 is pending, with an ack landing in the reset cycle.
    applyStimulus(0, 1, 1, 2, 1, 15'h013F, 15'h0140, 32'hCAFEF00D, 1, 4'b0001, 1);
    applyStimulus(1, 1, 1, 2, 1, 15'h013F, 15'h0140, 32'hCAFEF00D, 1, 4'b0001, 1);
    @(negedge clk);
    checkOutput("rb2_req", 32'(o_mem_req), 0);
    checkOutput("rb2_retire", 32'(o_retire), 0);
    checkOutput("rb2_we1", 32'(o_reg_we1), 0);
    applyStimulus(0, 1, 1, 2, 1, 15'h013F, 15'h0140, 32'hCAFEF00D, 0, 4'b0001, 1);
    @(negedge clk);
    checkOutput("rb2_idle_addr", 32'(o_mem_addr), 32'h013F);
    checkOutput("rb2_cnt", 32'(o_store_cnt), 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 1);

    // Back-to-back single-beat stores up to the counter wrap.
    for (int i = 0; i < 65535; i++) begin
      applyStimulus(0, 1, 1, 0, 0, 15'h0050, 0, 32'h0000005A, 1, 4'b0000, 1);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 1);
    @(negedge clk);
    checkOutput("wrap_full", 32'(o_store_cnt), 32'h0000FFFF);
    applyStimulus(0, 1, 1, 0, 0, 15'h0050, 0, 32'h0000005A, 1, 4'b0000, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 1);
    @(negedge clk);
    checkOutput("wrap_zero", 32'(o_store_cnt), 32'h00000000);

    @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_store_ctrl.md
Name: wb_store_ctrl

Overview:
- Writeback-stage control block. Sits directly downstream of the WB pipeline latch and consumes its outputs.
- Performs the stage's memory store to the data cache. A store that crosses a line boundary is split into two beats.
- Stalls the WB latch until the store completes. Emits one-cycle retire-qualified register, segment and flag write enables.
- Keeps a wrapping count of retired stores.

Parameters:
- PA_W, 15, physical address width (PA1/PA2 and memory address).
- DATA_W, 32, store data width; must equal 32.
- CNT_W, 16, width of the retired-store counter.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- i_v  input  1  WB latch holds a valid instruction
- i_mem_wr  input  1  instruction stores data1 to memory (decoded CS bit)
- i_cachable  input  1  store target is cachable
- i_data1  input  32  store data, little-endian, byte 0 = lowest address
- i_PA1  input  PA_W  physical address of first store byte
- i_PA2  input  PA_W  line-aligned physical address of the next line (used only when split)
- i_size1  input  2  store size: 0=1B, 1=2B, 2=4B, 3=4B
- i_spill  input  2  number of bytes that fall in the next line (0 = no split)
- i_reg_we1, i_reg_we2, i_seg_we, i_flag_we  input  1 each  decoded write requests for dr1, dr2, drSeg, eflags
- i_mem_ack  input  1  cache accepted the current request this cycle
- o_mem_req  output  1  store request valid
- o_mem_addr  output  PA_W  request byte address
- o_mem_wdata  output  32  request data, first byte in lane 0
- o_mem_nbytes  output  3  bytes in this beat (1..4)
- o_mem_uc  output  1  uncachable access (= ~i_cachable)
- o_stall  output  1  hold the WB latch (drives the latch's stall input)
- o_retire  output  1  instruction completes this cycle
- o_reg_we1, o_reg_we2, o_seg_we, o_flag_we  output  1 each  write enables, each = input request & o_retire
- o_store_cnt  output  CNT_W  retired stores, wraps

Behaviour:
- Clocking and reset:
  - One clock, clk. Reset rst is synchronous and active-high.
  - Reset puts the FSM in IDLE and clears o_store_cnt to 0.
  - While rst is high: o_mem_req, o_retire and all write enables are 0, and o_stall is 0.
- Size rules:
  - n = 1, 2, 4 for i_size1 = 0, 1, 2; i_size1 = 3 gives n = 4.
  - Effective spill s = i_spill if i_spill < n, else 0.
- Beat content:
  - Beat 1: addr i_PA1, nbytes n-s, wdata = i_data1 unchanged.
  - Beat 2: addr i_PA2, nbytes s, wdata = i_data1 >> 8*(n-s), zero-filled.
- FSM state IDLE:
  - If i_v & i_mem_wr: o_mem_req=1 with beat 1 fields.
  - On i_mem_ack with s=0: retire and stay in IDLE.
  - On i_mem_ack with s≠0: go to BEAT2, no retire.
  - Without ack: hold the request with the same fields.
- FSM state BEAT2:
  - o_mem_req=1 with beat 2 fields.
  - On i_mem_ack: retire and go to IDLE. Otherwise hold.
- Non-store instructions:
  - i_v & ~i_mem_wr in IDLE retires in the same cycle (combinational).
  - No request is issued; o_stall=0.
- Stall and retire timing:
  - o_stall = i_v & i_mem_wr & ~o_retire. It is combinational on i_mem_ack, so the latch advances in the same cycle as the final ack.
  - o_retire is a single-cycle pulse per instruction. Latch inputs are stable while o_stall=1.
  - A store is never retired twice, and beat 1 is never reissued after it has been acked.
- Request fields are driven from the latch outputs and the FSM state. Fields are undefined while o_mem_req=0.
- i_v=0 in IDLE: no request, no retire, no stall.
- Counter: o_store_cnt increments on o_retire & i_mem_wr, wrapping from 2^CNT_W-1 to 0.
- Reset mid-operation, including in BEAT2 with a request pending: return to IDLE and drop o_mem_req in that cycle. Nothing retires. The cache must disregard an ack that arrives in a reset cycle.

Test Plan:
- Reset, then i_v=1, i_mem_wr=0, i_reg_we1=1 -> o_retire=1 and o_reg_we1=1 in the same cycle; o_stall=0, o_mem_req=0, count stays 0.
- 4B store, i_PA1=0x0100, i_data1=0xAABBCCDD, i_spill=0, ack delayed 3 cycles -> o_stall=1 and request held stable for 3 cycles. Retire on the ack cycle with nbytes=4 and wdata=0xAABBCCDD; o_store_cnt=1.
- Split 4B store, i_PA1=0x010E, i_PA2=0x0110, i_spill=2, data 0x11223344, ack immediate -> beat 1 addr 0x010E, nbytes 2, wdata 0x11223344. Beat 2 next cycle: addr 0x0110, nbytes 2, wdata 0x00001122. Retire only on the beat 2 ack.
- 1B store with i_spill=3 (invalid) -> single beat, nbytes=1, no BEAT2.
- rst asserted while in BEAT2 with request pending -> next cycle IDLE, o_mem_req=0, no retire, o_store_cnt=0.
- Preload the counter to 0xFFFF by retiring 65535 stores, retire one more -> o_store_cnt=0x0000.
